// File: rtl/usb_tx_encoder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// usb_tx_encoder
//
// USB full-speed transmit line encoder. Takes packet bytes over a valid/ready
// handshake, prepends SYNC, serialises LSB first, inserts stuff bits after six
// consecutive ones, NRZI-encodes onto D+/D- and closes every packet with
// EOP (SE0, SE0, J).
//
// Optional feature (compile-time macro USB_TX_CRC16_EN):
//   When defined, a CRC16 over every byte after the PID is appended after the
//   tx_last byte (16 bits, LSB first, stuffed like data). When undefined there
//   is no CRC logic and EOP follows the tx_last byte directly.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per USB bit period (>= 2)
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   tx_data   packet byte (first byte of a packet is the PID)
//   tx_valid  tx_data / tx_last valid
//   tx_last   marks the final byte of the packet
//   tx_ready  holding register empty; byte taken on clk when tx_valid & tx_ready
//   dp_out    D+ line level
//   dm_out    D- line level
//   tx_busy   packet on the wire (SYNC through the EOP J bit)
//   tx_err    one-cycle pulse when a packet is aborted on underrun
// -----------------------------------------------------------------------------
module usb_tx_encoder #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic       dp_out,
   output logic       dm_out,
   output logic       tx_busy,
   output logic       tx_err
);

   localparam int                 CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   // Each state names the kind of bit currently on the wire.
   typedef enum logic [2:0] {
      S_IDLE,
      S_SYNC,
      S_DATA,
      S_CRC,
      S_EOP_SE0,
      S_EOP_J
   } state_t;

   state_t           state_q,      state_d;
   logic [CNT_W-1:0] bit_cnt_q,    bit_cnt_d;
   logic [3:0]       bit_idx_q,    bit_idx_d;    // index of last payload bit sent
   logic [2:0]       ones_q,       ones_d;       // consecutive logical ones on the wire
   logic             line_j_q,     line_j_d;     // NRZI level, 1 = J
   logic [7:0]       hold_data_q,  hold_data_d;
   logic             hold_last_q,  hold_last_d;
   logic             hold_full_q,  hold_full_d;
   logic [7:0]       shift_q,      shift_d;      // bit 0 is the next bit to send
   logic             shift_last_q, shift_last_d;
   logic             tx_err_q,     tx_err_d;
`ifdef USB_TX_CRC16_EN
   logic [15:0]      crc_q,        crc_d;        // running CRC, then CRC tx shifter
   logic             is_pid_q,     is_pid_d;
   logic             data_bit;
`endif

   logic bit_end;
   logic emit;
   logic emit_bit;
   logic stuff;
   logic load;

   always_comb begin
      // NOTE: every *_d gets its current value first, so no path through this block leaves a latch.
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      bit_idx_d    = bit_idx_q;
      ones_d       = ones_q;
      line_j_d     = line_j_q;
      hold_data_d  = hold_data_q;
      hold_last_d  = hold_last_q;
      hold_full_d  = hold_full_q;
      shift_d      = shift_q;
      shift_last_d = shift_last_q;
      tx_err_d     = 1'b0;
`ifdef USB_TX_CRC16_EN
      crc_d        = crc_q;
      is_pid_d     = is_pid_q;
      data_bit     = 1'b0;
`endif
      emit         = 1'b0;
      emit_bit     = 1'b0;
      stuff        = 1'b0;
      load         = 1'b0;
      bit_end      = (bit_cnt_q == CNT_LAST);

      if (state_q != S_IDLE) begin
         bit_cnt_d = bit_end ? '0 : bit_cnt_q + 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            // First SYNC bit (a 0, so the line goes to K) starts on this edge.
            if (hold_full_q) begin
               state_d   = S_SYNC;
               bit_idx_d = '0;
               emit      = 1'b1;
               emit_bit  = 1'b0;
`ifdef USB_TX_CRC16_EN
               crc_d     = 16'hFFFF;
`endif
            end
         end

         S_SYNC: begin
            if (bit_end) begin
               if (bit_idx_q == 4'd7) begin
                  state_d = S_DATA;
                  load    = 1'b1;
               end else begin
                  bit_idx_d = bit_idx_q + 4'd1;
                  emit      = 1'b1;
                  emit_bit  = (bit_idx_q == 4'd6);   // SYNC = 0000_0001 LSB first
               end
            end
         end

         S_DATA: begin
            if (bit_end) begin
               if (ones_q == 3'd6) begin
                  stuff = 1'b1;                     // owed stuff bit goes before anything else
               end else if (bit_idx_q != 4'd7) begin
                  bit_idx_d = bit_idx_q + 4'd1;
                  emit      = 1'b1;
                  emit_bit  = shift_q[0];
                  shift_d   = {1'b0, shift_q[7:1]};
`ifdef USB_TX_CRC16_EN
                  data_bit  = 1'b1;
`endif
               end else if (shift_last_q) begin
`ifdef USB_TX_CRC16_EN
                  // CRC is sent complemented; reuse crc_q as its shifter.
                  state_d   = S_CRC;
                  bit_idx_d = '0;
                  emit      = 1'b1;
                  emit_bit  = ~crc_q[0];
                  crc_d     = {1'b0, ~crc_q[15:1]};
`else
                  state_d   = S_EOP_SE0;
                  bit_idx_d = '0;
`endif
               end else if (hold_full_q) begin
                  load = 1'b1;
               end else begin
                  tx_err_d  = 1'b1;
                  state_d   = S_EOP_SE0;
                  bit_idx_d = '0;
               end
            end
         end

`ifdef USB_TX_CRC16_EN
         S_CRC: begin
            if (bit_end) begin
               if (ones_q == 3'd6) begin
                  stuff = 1'b1;
               end else if (bit_idx_q != 4'd15) begin
                  bit_idx_d = bit_idx_q + 4'd1;
                  emit      = 1'b1;
                  emit_bit  = crc_q[0];
                  crc_d     = {1'b0, crc_q[15:1]};
               end else begin
                  state_d   = S_EOP_SE0;
                  bit_idx_d = '0;
               end
            end
         end
`endif

         S_EOP_SE0: begin
            if (bit_end) begin
               if (bit_idx_q == 4'd0) begin
                  bit_idx_d = 4'd1;
               end else begin
                  state_d  = S_EOP_J;
                  line_j_d = 1'b1;
               end
            end
         end

         S_EOP_J: begin
            if (bit_end) begin
               state_d = S_IDLE;
               ones_d  = '0;
            end
         end

         default: state_d = S_IDLE;
      endcase

      // Holding register -> shifter; first bit of the byte starts on this edge.
      if (load) begin
         shift_d      = {1'b0, hold_data_q[7:1]};
         shift_last_d = hold_last_q;
         hold_full_d  = 1'b0;
         bit_idx_d    = '0;
         emit         = 1'b1;
         emit_bit     = hold_data_q[0];
`ifdef USB_TX_CRC16_EN
         is_pid_d     = (state_q == S_SYNC);
         data_bit     = 1'b1;
`endif
      end

      if (tx_valid && !hold_full_q) begin
         hold_data_d = tx_data;
         hold_last_d = tx_last;
         hold_full_d = 1'b1;
      end

      // NRZI: a 0 (data or stuff) toggles the line, a 1 holds it.
      if (stuff) begin
         line_j_d = ~line_j_q;
         ones_d   = '0;
      end else if (emit) begin
         if (emit_bit) begin
            ones_d = ones_q + 3'd1;
         end else begin
            ones_d   = '0;
            line_j_d = ~line_j_q;
         end
      end

`ifdef USB_TX_CRC16_EN
      // Reflected form of x^16+x^15+x^2+1, fed LSB first; the PID is excluded.
      if (data_bit && !is_pid_d) begin
         crc_d = {1'b0, crc_q[15:1]} ^ (((crc_q[0] ^ emit_bit) != 1'b0) ? 16'hA001 : 16'h0000);
      end
`endif
   end

   // NOTE: sequential state uses non-blocking assignments only; the block above uses blocking ones.
   // NOTE: holding register, shifter and CRC are reset with the control state so an abort leaves no stale byte.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         bit_cnt_q    <= '0;
         bit_idx_q    <= '0;
         ones_q       <= '0;
         line_j_q     <= 1'b1;
         hold_data_q  <= '0;
         hold_last_q  <= 1'b0;
         hold_full_q  <= 1'b0;
         shift_q      <= '0;
         shift_last_q <= 1'b0;
         tx_err_q     <= 1'b0;
`ifdef USB_TX_CRC16_EN
         crc_q        <= 16'hFFFF;
         is_pid_q     <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         bit_idx_q    <= bit_idx_d;
         ones_q       <= ones_d;
         line_j_q     <= line_j_d;
         hold_data_q  <= hold_data_d;
         hold_last_q  <= hold_last_d;
         hold_full_q  <= hold_full_d;
         shift_q      <= shift_d;
         shift_last_q <= shift_last_d;
         tx_err_q     <= tx_err_d;
`ifdef USB_TX_CRC16_EN
         crc_q        <= crc_d;
         is_pid_q     <= is_pid_d;
`endif
      end
   end

   assign tx_ready = ~hold_full_q;
   assign tx_busy  = (state_q != S_IDLE);
   assign tx_err   = tx_err_q;
   assign dp_out   = (state_q == S_EOP_SE0) ? 1'b0 : line_j_q;
   assign dm_out   = (state_q == S_EOP_SE0) ? 1'b0 : ~line_j_q;

endmodule

// File: tb/tb_usb_tx_encoder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_usb_tx_encoder
//
// Self-checking bench for usb_tx_encoder. A reference model turns a packet
// (list of bytes, terminated or underrun) into the expected wire symbols per
// bit period; the bench feeds bytes as soon as tx_ready allows, records the
// line, tx_busy, tx_err and tx_ready every cycle, and compares.
// Honours USB_TX_CRC16_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_usb_tx_encoder;

   localparam int CPB = 4;

   typedef logic [7:0] byte_q_t[$];
   typedef logic [1:0] sym_q_t[$];
   typedef int         int_q_t[$];

   localparam logic [1:0] SYM_J   = 2'b10;   // {dp, dm}
   localparam logic [1:0] SYM_K   = 2'b01;
   localparam logic [1:0] SYM_SE0 = 2'b00;

`ifdef USB_TX_CRC16_EN
   localparam int BUSY_00 = 140;
   localparam int BUSY_FF = 144;
   localparam int BUSY_C3 = 140;
`else
   localparam int BUSY_00 = 76;
   localparam int BUSY_FF = 80;
   localparam int BUSY_C3 = 76;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_last;
   logic       tx_ready;
   logic       dp_out;
   logic       dm_out;
   logic       tx_busy;
   logic       tx_err;

   int errors = 0;
   int checks = 0;

   usb_tx_encoder #(.CLKS_PER_BIT(CPB)) dut (
      .clk      (clk),
      .rst      (rst),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_last  (tx_last),
      .tx_ready (tx_ready),
      .dp_out   (dp_out),
      .dm_out   (dm_out),
      .tx_busy  (tx_busy),
      .tx_err   (tx_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // CRC16 computed in the plain MSB-first form on bit-reversed bytes.
   function automatic logic [15:0] crc16_model(input byte_q_t bytes);
      logic [15:0] c = 16'hFFFF;
      logic [15:0] r;
      logic        fb;
      for (int b = 1; b < bytes.size(); b++) begin
         for (int k = 0; k < 8; k++) begin
            fb = c[15] ^ bytes[b][k];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
         end
      end
      for (int k = 0; k < 16; k++) r[k] = c[15-k];
      return ~r;
   endfunction

   // Expected symbol per bit period, index of the first SE0 when aborted
   // (-1 otherwise) and the bit period where each byte's first bit starts.
   function automatic void build_model(input byte_q_t bytes, input bit ended,
                                       output sym_q_t syms, output int err_idx,
                                       output int_q_t first_sym);
      bit          lb[$];
      bit          lvl;
      int          ones;
`ifdef USB_TX_CRC16_EN
      logic [15:0] crc;
`endif
      syms      = {};
      first_sym = {};
      for (int k = 0; k < 8; k++) lb.push_back(k == 7);
      foreach (bytes[b]) for (int k = 0; k < 8; k++) lb.push_back(bytes[b][k]);
`ifdef USB_TX_CRC16_EN
      if (ended) begin
         crc = crc16_model(bytes);
         for (int k = 0; k < 16; k++) lb.push_back(crc[k]);
      end
`endif
      lvl  = 1'b1;
      ones = 0;
      foreach (lb[i]) begin
         if (i >= 8 && ((i - 8) % 8) == 0 && ((i - 8) / 8) < bytes.size())
            first_sym.push_back(syms.size());
         if (lb[i]) ones++;
         else begin
            lvl  = ~lvl;
            ones = 0;
         end
         syms.push_back(lvl ? SYM_J : SYM_K);
         if (ones == 6) begin
            lvl  = ~lvl;
            ones = 0;
            syms.push_back(lvl ? SYM_J : SYM_K);
         end
      end
      err_idx = ended ? -1 : syms.size();
      syms.push_back(SYM_SE0);
      syms.push_back(SYM_SE0);
      syms.push_back(SYM_J);
   endfunction

   task automatic run_packet(input string tag, input byte_q_t bytes, input bit ended,
                             output int busy_cnt);
      sym_q_t     syms;
      int_q_t     first_sym;
      int         err_idx;
      int         nsym;
      int         n;
      int         idx;
      logic [3:0] rec[$];
      logic       rec_rdy[$];
      logic [1:0] es;
      logic       eb;
      logic       ee;

      build_model(bytes, ended, syms, err_idx, first_sym);
      nsym = syms.size();
      n    = 1 + nsym * CPB + 3;

      @(negedge clk);
      check({tag, "_ready_idle"}, tx_ready, 1);
      tx_data  = bytes[0];
      tx_last  = ended && (bytes.size() == 1);
      tx_valid = 1'b1;
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      tx_last  = 1'b0;
      check({tag, "_ready_after_accept"}, tx_ready, 0);

      fork
         begin
            for (int i = 1; i < bytes.size(); i++) begin
               int w;
               w = 0;
               @(negedge clk);
               while (tx_ready !== 1'b1 && w < 500) begin
                  @(negedge clk);
                  w++;
               end
               check($sformatf("%s_feed%0d_wait", tag, i), (w < 500), 1);
               tx_data  = bytes[i];
               tx_last  = ended && (i == bytes.size() - 1);
               tx_valid = 1'b1;
               @(posedge clk);
               #1;
               tx_valid = 1'b0;
               tx_last  = 1'b0;
            end
         end
         begin
            for (int i = 0; i < n; i++) begin
               @(negedge clk);
               rec.push_back({dp_out, dm_out, tx_busy, tx_err});
               rec_rdy.push_back(tx_ready);
            end
         end
      join

      busy_cnt = 0;
      for (int i = 0; i < n; i++) begin
         eb = (i >= 1) && (i <= nsym * CPB);
         es = eb ? syms[(i - 1) / CPB] : SYM_J;
         ee = (err_idx >= 0) && (i == 1 + err_idx * CPB);
         check($sformatf("%s_cyc%0d", tag, i), rec[i], {es, eb, ee});
         if (rec[i][1]) busy_cnt++;
      end
      foreach (first_sym[b]) begin
         idx = 1 + first_sym[b] * CPB;
         check($sformatf("%s_rdy_pre_load%0d", tag, b), rec_rdy[idx - 1], 0);
         check($sformatf("%s_rdy_post_load%0d", tag, b), rec_rdy[idx], 1);
      end
      check({tag, "_busy_total"}, busy_cnt, nsym * CPB);
   endtask

   initial begin
      byte_q_t pkt;
      int      bc;
      int      len;
      bit      ended;

      rst      = 1'b1;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      tx_last  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_dp",    dp_out,   1);
      check("rst_dm",    dm_out,   0);
      check("rst_ready", tx_ready, 1);
      check("rst_busy",  tx_busy,  0);
      check("rst_err",   tx_err,   0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_line", {dp_out, dm_out, tx_busy}, {SYM_J, 1'b0});

      pkt = {8'h00};
      run_packet("single_00", pkt, 1'b1, bc);
      check("single_00_busy76", bc, BUSY_00);

      pkt = {8'hFF};
      run_packet("single_ff", pkt, 1'b1, bc);
      check("single_ff_busy", bc, BUSY_FF);

      pkt = {8'hC3, 8'h3C};
      run_packet("two_byte", pkt, 1'b1, bc);

      pkt = {8'hA5};
      run_packet("underrun", pkt, 1'b0, bc);

      pkt = {8'hC3};
      run_packet("pid_only", pkt, 1'b1, bc);
      check("pid_only_busy", bc, BUSY_C3);

      pkt = {8'hD2, 8'hFF, 8'hFF, 8'h01};
      run_packet("stuff_run", pkt, 1'b1, bc);

      // Asynchronous reset in the middle of the PID's data bits.
      @(negedge clk);
      tx_data  = 8'h5A;
      tx_last  = 1'b1;
      tx_valid = 1'b1;
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      tx_last  = 1'b0;
      repeat (40) @(negedge clk);
      check("mid_busy_before_rst", tx_busy, 1);
      rst = 1'b1;
      #1;
      check("mid_rst_dp",    dp_out,   1);
      check("mid_rst_dm",    dm_out,   0);
      check("mid_rst_busy",  tx_busy,  0);
      check("mid_rst_ready", tx_ready, 1);
      check("mid_rst_err",   tx_err,   0);
      @(negedge clk);
      rst = 1'b0;
      pkt = {8'h69, 8'h00};
      run_packet("after_rst", pkt, 1'b1, bc);

      for (int p = 0; p < 8; p++) begin
         len   = $urandom_range(1, 4);
         ended = ($urandom_range(0, 3) != 0);
         pkt   = {};
         for (int i = 0; i < len; i++)
            pkt.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom()));
         run_packet($sformatf("rand%0d", p), pkt, ended, bc);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
